mem_arbiter: RTL

//  Shares one 16-bit-data / 32-bit-address memory port between the rcpu core and a DMA requester.
//  CPU writes are never stalled by the core, so they are posted into a small write buffer and drained later.
//  CPU reads stall via cpuReady. A DMA starvation counter bounds DMA wait time.

---
 rtl/mem_arbiter_pkg.sv | 22 ++
 rtl/wb_fifo.sv | 60 ++++++
 rtl/mem_arbiter.sv | 170 +++++++++++++++++
 3 files changed

// File: rtl/mem_arbiter_pkg.sv
// Shared constants for the memory-port arbiter.
//   arb_state_e : arbiter FSM states (IDLE, WB_DRAIN, CPU_RD, DMA_XFER)
//   wb_entry_w  : width of one write-buffer entry ({address, data})
package mem_arbiter_pkg;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        WB_DRAIN = 2'd1,
        CPU_RD   = 2'd2,
        DMA_XFER = 2'd3
    } arb_state_e;

    localparam int unsigned DEF_ADDR_W = 32;
    localparam int unsigned DEF_DATA_W = 16;

    function automatic int unsigned wb_entry_w(input int unsigned addr_w, input int unsigned data_w);
        return addr_w + data_w;
    endfunction

    localparam int unsigned WB_ENTRY_W = wb_entry_w(DEF_ADDR_W, DEF_DATA_W);

endpackage

// File: rtl/wb_fifo.sv
// Synchronous FIFO used as the posted CPU write buffer.
//   clk, rst_n : clock, asynchronous active-low reset (empties the FIFO)
//   push_i     : enqueue din_i (ignored when full unless a pop happens in the same cycle)
//   pop_i      : dequeue head (ignored when empty)
//   din_i      : entry to enqueue
//   head_o     : oldest entry
//   full_o     : DEPTH entries stored
//   empty_o    : no entries stored
module wb_fifo #(
    parameter int unsigned DEPTH = 4,
    parameter int unsigned W     = 48
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         push_i,
    input  logic         pop_i,
    input  logic [W-1:0] din_i,
    output logic [W-1:0] head_o,
    output logic         full_o,
    output logic         empty_o
);

    localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [W-1:0]  mem_q [DEPTH];
    logic [AW-1:0] wr_ptr_q, rd_ptr_q;
    logic [AW:0]   count_q;
    logic          do_push, do_pop;

    assign full_o  = (count_q == (AW+1)'(DEPTH));
    assign empty_o = (count_q == '0);
    assign head_o  = mem_q[rd_ptr_q];

    // A pop frees a slot in the same cycle, so a push into a full FIFO is accepted then.
    assign do_pop  = pop_i && !empty_o;
    assign do_push = push_i && (!full_o || do_pop);

    always_ff @(posedge clk) begin
        if (do_push) begin
            mem_q[wr_ptr_q] <= din_i;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (do_push) wr_ptr_q <= wr_ptr_q + 1'b1;
            if (do_pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
            case ({do_push, do_pop})
                2'b10:   count_q <= count_q + 1'b1;
                2'b01:   count_q <= count_q - 1'b1;
                default: count_q <= count_q;
            endcase
        end
    end

endmodule

// File: rtl/mem_arbiter.sv
// Arbitrates one memory port between rcpu (posted writes, stalling reads) and a DMA requester.
//   clk, rst          : clock, asynchronous active-low reset
//   cpuAddr/cpuWData  : CPU address / write data
//   cpuRE/cpuWE       : CPU read request (level) / write strobe (one write per high cycle)
//   cpuRData/cpuReady : CPU read data (memRData passthrough) / low stalls the CPU read
//   dmaReq/dmaWE      : DMA request (held until dmaAck) / 1=write
//   dmaAddr/dmaWData  : DMA address / write data
//   dmaRData/dmaAck   : DMA read data (valid with dmaAck) / one-cycle completion
//   memAddr/memWData  : slave address / write data (registered)
//   memRE/memWE       : slave strobes, held until memAck
//   memRData/memAck   : slave read data / one-cycle completion
//   wbOverflow        : sticky flag, a CPU write was dropped on a full buffer
module mem_arbiter
    import mem_arbiter_pkg::*;
#(
    parameter int unsigned N        = 32,
    parameter int unsigned M        = 16,
    parameter int unsigned WB_DEPTH = 4,
    parameter int unsigned MAX_WAIT = 8
) (
    input  logic         clk,
    input  logic         rst,
    input  logic [N-1:0] cpuAddr,
    input  logic [M-1:0] cpuWData,
    input  logic         cpuRE,
    input  logic         cpuWE,
    output logic [M-1:0] cpuRData,
    output logic         cpuReady,
    input  logic         dmaReq,
    input  logic         dmaWE,
    input  logic [N-1:0] dmaAddr,
    input  logic [M-1:0] dmaWData,
    output logic [M-1:0] dmaRData,
    output logic         dmaAck,
    output logic [N-1:0] memAddr,
    output logic [M-1:0] memWData,
    output logic         memRE,
    output logic         memWE,
    input  logic [M-1:0] memRData,
    input  logic         memAck,
    output logic         wbOverflow
);

    localparam int unsigned   EW         = wb_entry_w(N, M);
    localparam int unsigned   CW         = $clog2(MAX_WAIT + 1);
    localparam logic [CW-1:0] WAIT_LIMIT = CW'(MAX_WAIT);

    arb_state_e    state_q, state_d;
    logic [N-1:0]  addr_q, addr_d;
    logic [M-1:0]  wdata_q, wdata_d;
    logic          re_q, re_d, we_q, we_d;
    logic [CW-1:0] wait_q, wait_d;
    logic          ovf_q, ovf_d;

    logic          wb_full, wb_empty, wb_pop;
    logic [EW-1:0] wb_head, wb_din;
    logic          dma_ack;

    assign wb_din = {cpuAddr, cpuWData};
    assign wb_pop = (state_q == WB_DRAIN) && memAck;

    wb_fifo #(
        .DEPTH(WB_DEPTH),
        .W    (EW)
    ) u_wb_fifo (
        .clk    (clk),
        .rst_n  (rst),
        .push_i (cpuWE),
        .pop_i  (wb_pop),
        .din_i  (wb_din),
        .head_o (wb_head),
        .full_o (wb_full),
        .empty_o(wb_empty)
    );

    assign dma_ack    = (state_q == DMA_XFER) && memAck;
    assign dmaAck     = dma_ack;
    assign dmaRData   = dma_ack ? memRData : '0;
    assign cpuRData   = memRData;
    assign cpuReady   = !cpuRE || ((state_q == CPU_RD) && memAck);
    assign memAddr    = addr_q;
    assign memWData   = wdata_q;
    assign memRE      = re_q;
    assign memWE      = we_q;
    assign wbOverflow = ovf_q;

    // Arbitration picks the next state first; the master registers are then
    // loaded from the winner so they stay constant for the whole transaction.
    always_comb begin
        state_d = state_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        re_d    = re_q;
        we_d    = we_q;

        case (state_q)
            IDLE: begin
                if (dmaReq && (wait_q >= WAIT_LIMIT)) state_d = DMA_XFER;
                else if (!wb_empty)                   state_d = WB_DRAIN;
                else if (cpuRE)                       state_d = CPU_RD;
                else if (dmaReq)                      state_d = DMA_XFER;
            end
            WB_DRAIN, CPU_RD, DMA_XFER: begin
                if (memAck) begin
                    state_d = IDLE;
                    re_d    = 1'b0;
                    we_d    = 1'b0;
                end
            end
            default: state_d = IDLE;
        endcase

        if (state_q == IDLE) begin
            case (state_d)
                WB_DRAIN: begin
                    addr_d  = wb_head[EW-1 -: N];
                    wdata_d = wb_head[M-1:0];
                    we_d    = 1'b1;
                end
                CPU_RD: begin
                    addr_d = cpuAddr;
                    re_d   = 1'b1;
                end
                DMA_XFER: begin
                    addr_d  = dmaAddr;
                    wdata_d = dmaWData;
                    we_d    = dmaWE;
                    re_d    = !dmaWE;
                end
                default: ;
            endcase
        end
    end

    always_comb begin
        wait_d = wait_q;
        if (dma_ack) begin
            wait_d = '0;
        end else if (dmaReq && (state_q != DMA_XFER) && (wait_q < WAIT_LIMIT)) begin
            wait_d = wait_q + 1'b1;
        end
    end

    assign ovf_d = ovf_q || (cpuWE && wb_full && !wb_pop);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= IDLE;
            addr_q  <= '0;
            wdata_q <= '0;
            re_q    <= 1'b0;
            we_q    <= 1'b0;
            wait_q  <= '0;
            ovf_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            re_q    <= re_d;
            we_q    <= we_d;
            wait_q  <= wait_d;
            ovf_q   <= ovf_d;
        end
    end

    // DMA must keep its request up until the transfer completes.
    dma_req_held_a: assert property (@(posedge clk) disable iff (!rst)
        (state_q == DMA_XFER) |-> dmaReq);

endmodule
